// File: rtl/freq_period_divider_pkg.sv
// Shared types and helpers for the frequency-to-period converter.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: scanner FSM state encoding and an index-width helper.
package freq_period_divider_pkg;

  // Scanner FSM: IDLE examines one channel per cycle, LOAD snapshots the
  // frequency, DIV runs the shared serial divider, STORE clamps and writes.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DIV   = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  // Width of a channel pointer; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_period_divider_core.sv
// Serial restoring divider, one quotient bit per cycle, shared by all channels.
// Latency: start sampled on an edge, quotient valid BIT_WIDTH edges later.
// Backpressure: none; a new start simply restarts the division.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                load dividend/divisor and begin (ignored work is aborted)
//   dividend, divisor    operands, sampled only when start is high
//   last                 high during the cycle whose edge produces the final bit
//   quotient             quotient register (final once last has been seen)
module freq_period_divider_core #(
  parameter int BIT_WIDTH = 32,
  parameter int DIVISOR_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] dividend,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic                 last,
  output logic [BIT_WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(BIT_WIDTH + 1);

  logic                 run_q, run_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH:0]   rem_q, rem_d;
  logic [BIT_WIDTH-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0] div_q, div_d;

  logic [BIT_WIDTH:0]   rem_shift;
  logic [BIT_WIDTH:0]   div_ext;
  logic [BIT_WIDTH:0]   rem_sub;
  logic                 fits;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while new quotient bits enter at the LSB.
    rem_shift = {rem_q[BIT_WIDTH-1:0], quo_q[BIT_WIDTH-1]};
    div_ext   = {{(BIT_WIDTH + 1 - DIVISOR_W){1'b0}}, div_q};
    rem_sub   = rem_shift - div_ext;
    // A set top bit means the shifted remainder overflowed the window, so the
    // divisor certainly fits; the modular subtraction is still exact.
    fits      = rem_q[BIT_WIDTH] | (rem_shift >= div_ext);

    if (start) begin
      run_d = 1'b1;
      cnt_d = CNT_W'(BIT_WIDTH);
      rem_d = '0;
      quo_d = dividend;
      div_d = divisor;
    end else if (run_q) begin
      rem_d = fits ? rem_sub : rem_shift;
      quo_d = {quo_q[BIT_WIDTH-2:0], fits};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
    end
  end

  assign last     = run_q && (cnt_q == CNT_W'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/freq_period_divider.sv
// Multi-channel frequency-to-period converter: period = TARGET / freq, clamped.
// Latency: period written BIT_WIDTH+3 cycles after the selecting IDLE cycle (3 if freq==0).
// Backpressure: none; inputs are sampled freely, changes are picked up on the next scan.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset (aborts any division)
//   user_freq      N_CH packed frequencies in 0.1 kHz units, ch i at [i*FREQ_W +: FREQ_W]
//   pulse_period   N_CH packed registered periods in clock cycles
//   period_upd     per-channel one-cycle strobe when that period register is written
//   period_sat     per-channel level: last result was clamped or freq was zero
//   busy           high whenever the scanner is outside IDLE
//
// Build option FREQ_DIV_ROUND_EN: round to nearest (dividend TARGET + freq/2)
// instead of truncating; clamping and latency are unchanged.
module freq_period_divider
  import freq_period_divider_pkg::*;
#(
  parameter int CLK_FREQ_KHZ = 100_000,
  parameter int FREQ_SCALE   = 10,
  parameter int N_CH         = 4,
  parameter int FREQ_W       = 16,
  parameter int BIT_WIDTH    = 32,
  parameter int MAX_PERIOD   = 200_000,
  parameter int MIN_PERIOD   = 2,
  parameter int RESET_PERIOD = 2000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH*FREQ_W-1:0]    user_freq,
  output logic [N_CH*BIT_WIDTH-1:0] pulse_period,
  output logic [N_CH-1:0]           period_upd,
  output logic [N_CH-1:0]           period_sat,
  output logic                      busy
);

  localparam int PTR_W = idx_width(N_CH);
  // Elaboration-time constants only; no multiplier is built.
  localparam logic [BIT_WIDTH-1:0] TARGET  = BIT_WIDTH'(CLK_FREQ_KHZ * FREQ_SCALE);
  localparam logic [BIT_WIDTH-1:0] MAX_P   = BIT_WIDTH'(MAX_PERIOD);
  localparam logic [BIT_WIDTH-1:0] MIN_P   = BIT_WIDTH'(MIN_PERIOD);
  localparam logic [BIT_WIDTH-1:0] RESET_P = BIT_WIDTH'(RESET_PERIOD);

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [N_CH-1:0]      stale_q, stale_d;
  logic [FREQ_W-1:0]    cached_q [N_CH];
  logic [FREQ_W-1:0]    cached_d [N_CH];
  logic [FREQ_W-1:0]    snap_q, snap_d;
  logic [BIT_WIDTH-1:0] period_q [N_CH];
  logic [BIT_WIDTH-1:0] period_d [N_CH];
  logic [N_CH-1:0]      sat_q, sat_d;
  logic [N_CH-1:0]      upd_q, upd_d;

  logic [FREQ_W-1:0]    freq_in [N_CH];
  logic [FREQ_W-1:0]    cur_freq;
  logic [PTR_W-1:0]     ptr_next;
  logic [BIT_WIDTH-1:0] dividend;
  logic                 div_start;
  logic                 div_last;
  logic [BIT_WIDTH-1:0] div_quot;
  logic [BIT_WIDTH-1:0] res;
  logic                 res_sat;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign freq_in[i] = user_freq[i*FREQ_W +: FREQ_W];
    assign pulse_period[i*BIT_WIDTH +: BIT_WIDTH] = period_q[i];
  end

  assign cur_freq  = freq_in[ptr_q];
  assign ptr_next  = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + PTR_W'(1);
  // A zero frequency skips the divider entirely.
  assign div_start = (state_q == ST_LOAD) && (cur_freq != '0);

`ifdef FREQ_DIV_ROUND_EN
  assign dividend = TARGET + BIT_WIDTH'(cur_freq >> 1);
`else
  assign dividend = TARGET;
`endif

  freq_period_divider_core #(
    .BIT_WIDTH (BIT_WIDTH),
    .DIVISOR_W (FREQ_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (cur_freq),
    .last     (div_last),
    .quotient (div_quot)
  );

  // Clamp the finished quotient; the snapshot, not the live input, decides the
  // zero case so a mid-division input change cannot corrupt this result.
  always_comb begin
    res     = div_quot;
    res_sat = 1'b0;
    if ((snap_q == '0) || (div_quot > MAX_P)) begin
      res     = MAX_P;
      res_sat = 1'b1;
    end else if (div_quot < MIN_P) begin
      res     = MIN_P;
      res_sat = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    stale_d  = stale_q;
    cached_d = cached_q;
    snap_d   = snap_q;
    period_d = period_q;
    sat_d    = sat_q;
    upd_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (stale_q[ptr_q] || (cur_freq != cached_q[ptr_q])) begin
          state_d = ST_LOAD;
        end else begin
          ptr_d = ptr_next;
        end
      end
      ST_LOAD: begin
        snap_d         = cur_freq;
        stale_d[ptr_q] = 1'b0;
        state_d        = (cur_freq == '0) ? ST_STORE : ST_DIV;
      end
      ST_DIV: begin
        if (div_last) begin
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        period_d[ptr_q] = res;
        sat_d[ptr_q]    = res_sat;
        // Caching the snapshot (not the live input) makes a change that
        // arrived during DIV show up as a mismatch on the next visit.
        cached_d[ptr_q] = snap_q;
        upd_d[ptr_q]    = 1'b1;
        ptr_d           = ptr_next;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      stale_q <= '1;
      snap_q  <= '0;
      sat_q   <= '0;
      upd_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cached_q[i] <= '0;
        period_q[i] <= RESET_P;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      stale_q  <= stale_d;
      snap_q   <= snap_d;
      sat_q    <= sat_d;
      upd_q    <= upd_d;
      cached_q <= cached_d;
      period_q <= period_d;
    end
  end

  assign period_upd = upd_q;
  assign period_sat = sat_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
